// File: rtl/pe_traffic_gen.sv
// rtl/pe_traffic_gen.sv - synthetic NoC processing element: credit-based packet injector and flit sink
//
// Purpose:
//   Attaches to one router port of the CONNECT network. Injects a configured
//   run of packets on one VC under credit flow control, sinks ejected flits,
//   returns one credit per received flit and keeps traffic counters.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   cfg_start                    one-cycle pulse, latches cfg_* and starts a run (IDLE/DONE only)
//   cfg_dest/cfg_vc              destination node and VC for every flit of the run
//   cfg_pkt_len/cfg_num_pkts     flits per packet (0 means 1) and packets per run
//   cfg_gap                      idle cycles between tail and next head
//   flit_out                     to network putFlit: {valid, tail, dest, vc, data}
//   credit_in                    from network getCredits: {valid, vc}
//   flit_in                      from network getFlit
//   credit_out                   to network putCredits: {valid, vc}
//   busy/done                    run in progress / run finished
//   tx_flits/rx_flits/rx_pkts    wrapping traffic counters
//   rx_err                       sticky: credit overflow or misrouted flit

module pe_traffic_gen #(
  parameter int NODE_ID   = 0,
  parameter int DEST_BITS = 4,
  parameter int VC_BITS   = 1,
  parameter int NUM_VCS   = 2,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 2 + DEST_BITS + VC_BITS + DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_start,
  input  logic [DEST_BITS-1:0] cfg_dest,
  input  logic [VC_BITS-1:0]   cfg_vc,
  input  logic [7:0]           cfg_pkt_len,
  input  logic [15:0]          cfg_num_pkts,
  input  logic [7:0]           cfg_gap,
  output logic [FLIT_W-1:0]    flit_out,
  input  logic [VC_BITS:0]     credit_in,
  input  logic [FLIT_W-1:0]    flit_in,
  output logic [VC_BITS:0]     credit_out,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          tx_flits,
  output logic [31:0]          rx_flits,
  output logic [15:0]          rx_pkts,
  output logic                 rx_err
);

  localparam int CW    = $clog2(BUF_DEPTH + 1);
  localparam int SEQ_W = DATA_W - 8;
  localparam logic [CW-1:0]        CREDIT_MAX = CW'(BUF_DEPTH);
  localparam logic [DEST_BITS-1:0] MY_DEST    = DEST_BITS'(NODE_ID);
  localparam logic [7:0]           MY_ID      = 8'(NODE_ID);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t state, state_nxt;

  // Run configuration latched at start
  logic [DEST_BITS-1:0] run_dest;
  logic [VC_BITS-1:0]   run_vc;
  logic [7:0]           run_len;
  logic [15:0]          run_num;
  logic [7:0]           run_gap;

  logic [7:0]       flit_idx;   // index of the next flit to load within its packet
  logic [15:0]      pkt_idx;    // packets whose tail has already gone out
  logic [SEQ_W-1:0] seq;
  logic [7:0]       gap_cnt;
  logic [CW-1:0]    credit [NUM_VCS];

  // Values for the flit being loaded this cycle; a start loads the head
  // directly from the cfg_* inputs so it appears the cycle after the pulse.
  logic                 start_ok;
  logic [DEST_BITS-1:0] sel_dest;
  logic [VC_BITS-1:0]   sel_vc;
  logic [7:0]           sel_len;
  logic [7:0]           sel_flit_idx;
  logic [SEQ_W-1:0]     sel_seq;
  logic [CW-1:0]        cur_credit;
  logic                 load;
  logic                 load_tail;
  logic                 out_tail_seen;
  logic                 last_pkt;
  logic                 credit_ovf;

  logic                 ret_valid;
  logic [VC_BITS-1:0]   ret_vc;
  logic                 in_valid;
  logic                 in_tail;
  logic [DEST_BITS-1:0] in_dest;
  logic [VC_BITS-1:0]   in_vc;
  logic                 unused_in_data;

  assign start_ok     = cfg_start && (state == S_IDLE || state == S_DONE);
  assign sel_dest     = start_ok ? cfg_dest : run_dest;
  assign sel_vc       = start_ok ? cfg_vc : run_vc;
  assign sel_len      = start_ok ? ((cfg_pkt_len == 8'd0) ? 8'd1 : cfg_pkt_len) : run_len;
  assign sel_flit_idx = start_ok ? 8'd0 : flit_idx;
  assign sel_seq      = start_ok ? '0 : seq;
  assign load_tail    = (sel_flit_idx == sel_len - 8'd1);

  // The FSM reacts to the flit currently on flit_out, so a tail is seen
  // one cycle after it was loaded.
  assign out_tail_seen = flit_out[FLIT_W-1] && flit_out[FLIT_W-2];
  assign last_pkt      = (pkt_idx == run_num - 16'd1);

  assign ret_valid = credit_in[VC_BITS];
  assign ret_vc    = credit_in[VC_BITS-1:0];

  assign in_valid       = flit_in[FLIT_W-1];
  assign in_tail        = flit_in[FLIT_W-2];
  assign in_dest        = flit_in[FLIT_W-3 -: DEST_BITS];
  assign in_vc          = flit_in[DATA_W +: VC_BITS];
  assign unused_in_data = ^flit_in[DATA_W-1:0];

  assign busy = (state == S_SEND) || (state == S_GAP);
  assign done = (state == S_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_nxt = (cfg_num_pkts == 16'd0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (out_tail_seen) begin
          if (last_pkt) begin
            state_nxt = S_DONE;
          end else if (run_gap != 8'd0) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'd1) begin
          state_nxt = S_SEND;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered credit only: a return in this cycle cannot enable this load.
  always_comb begin
    cur_credit = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (sel_vc == VC_BITS'(v)) begin
        cur_credit = credit[v];
      end
    end
  end

  assign load = (state_nxt == S_SEND) && (cur_credit != '0);

  // A return on a VC that is already full and not sending this cycle.
  always_comb begin
    credit_ovf = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (ret_valid && ret_vc == VC_BITS'(v) && credit[v] == CREDIT_MAX &&
          !(load && sel_vc == VC_BITS'(v))) begin
        credit_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_dest   <= '0;
      run_vc     <= '0;
      run_len    <= 8'd1;
      run_num    <= 16'd0;
      run_gap    <= 8'd0;
      flit_idx   <= 8'd0;
      pkt_idx    <= 16'd0;
      seq        <= '0;
      gap_cnt    <= 8'd0;
      flit_out   <= '0;
      credit_out <= '0;
      tx_flits   <= 32'd0;
      rx_flits   <= 32'd0;
      rx_pkts    <= 16'd0;
      rx_err     <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit[v] <= CREDIT_MAX;
      end
    end else begin
      if (start_ok) begin
        run_dest <= cfg_dest;
        run_vc   <= cfg_vc;
        run_len  <= sel_len;
        run_num  <= cfg_num_pkts;
        run_gap  <= cfg_gap;
      end

      flit_out <= load ? {1'b1, load_tail, sel_dest, sel_vc, MY_ID, sel_seq} : '0;

      if (load) begin
        flit_idx <= load_tail ? 8'd0 : sel_flit_idx + 8'd1;
        seq      <= sel_seq + SEQ_W'(1);
        tx_flits <= tx_flits + 32'd1;
      end else if (start_ok) begin
        flit_idx <= 8'd0;
        seq      <= '0;
      end

      if (start_ok) begin
        pkt_idx <= 16'd0;
      end else if (state == S_SEND && out_tail_seen) begin
        pkt_idx <= pkt_idx + 16'd1;
      end

      if (state == S_SEND && state_nxt == S_GAP) begin
        gap_cnt <= run_gap;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      for (int v = 0; v < NUM_VCS; v++) begin
        if ((load && sel_vc == VC_BITS'(v)) && !(ret_valid && ret_vc == VC_BITS'(v))) begin
          credit[v] <= credit[v] - CW'(1);
        end else if (!(load && sel_vc == VC_BITS'(v)) && (ret_valid && ret_vc == VC_BITS'(v)) &&
                     credit[v] != CREDIT_MAX) begin
          credit[v] <= credit[v] + CW'(1);
        end
      end

      credit_out <= in_valid ? {1'b1, in_vc} : '0;
      if (in_valid) begin
        rx_flits <= rx_flits + 32'd1;
        if (in_tail) begin
          rx_pkts <= rx_pkts + 16'd1;
        end
      end

      if (credit_ovf || (in_valid && in_dest != MY_DEST)) begin
        rx_err <= 1'b1;
      end
    end
  end

endmodule
